// File: rtl/cpu_dbg_pkg.sv
// rtl/cpu_dbg_pkg.sv - shared types and encodings for the CPU run/halt/step controller
package cpu_dbg_pkg;

    // Debug sequencer states
    typedef enum logic [2:0] {
        ST_HALTED = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_FAULT  = 3'd3,
        ST_PCRST  = 3'd4
    } dbg_state_t;

    // Host command encodings on cmd_op; 6 and 7 are accepted and ignored
    localparam logic [2:0] CMD_HALT     = 3'd0;
    localparam logic [2:0] CMD_RUN      = 3'd1;
    localparam logic [2:0] CMD_STEP     = 3'd2;
    localparam logic [2:0] CMD_SET_BP   = 3'd3;
    localparam logic [2:0] CMD_CLR_BP   = 3'd4;
    localparam logic [2:0] CMD_RESET_PC = 3'd5;

    // Highest decoded opcode index the datapath implements
    localparam int OPI_MAX = 22;

endpackage

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/halt/single-step sequencer gating CPU architectural writes
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int CNT_W   = 16,
    parameter int OPI_MAX = cpu_dbg_pkg::OPI_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [PC_W-1:0]  cmd_arg,
    input  logic [PC_W-1:0]  pc,
    input  logic [4:0]       opi,
    input  logic             dec_pc_we,
    input  logic             dec_reg_write_en,
    input  logic             dec_flag_write_en,
    input  logic             dec_dmem_write_en,
    input  logic             dec_imem_we,
    output logic             pc_we,
    output logic             reg_write_en,
    output logic             flag_write_en,
    output logic             dmem_write_en,
    output logic             imem_we,
    output logic             pc_rst,
    output logic             halted,
    output logic             fault,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_cnt
);

    dbg_state_t        r_state;
    dbg_state_t        w_next_state;
    logic [PC_W-1:0]   r_bp_addr;
    logic              r_bp_en;
    logic [PC_W-1:0]   r_step_cnt;
    logic              r_first_cyc;
    logic              r_bp_hit;
    logic [CNT_W-1:0]  r_instr_cnt;

    logic              w_active;
    logic              w_fault_trap;
    logic              w_bp_trap;
    logic              w_exec;
    logic              w_cmd_acc;
    logic              w_cmd_move;
    dbg_state_t        w_cmd_state;
    logic              w_set_first;
    logic              w_load_step;
    logic              w_bp_take;

    // Trap detection and command-driven next state; fault beats commands, commands beat breakpoint/step completion
    always_comb begin
        w_active     = (r_state == ST_RUN) || (r_state == ST_STEP);
        w_fault_trap = w_active && ({27'd0, opi} > 32'(OPI_MAX));
        w_bp_trap    = (r_state == ST_RUN) && r_bp_en && (pc == r_bp_addr)
                       && !r_first_cyc && !w_fault_trap;
        w_exec       = w_active && !w_fault_trap && !w_bp_trap;
        cmd_ready    = (r_state != ST_PCRST);
        w_cmd_acc    = cmd_valid && cmd_ready;

        w_cmd_move  = 1'b0;
        w_cmd_state = r_state;
        if (w_cmd_acc) begin
            case (cmd_op)
                CMD_HALT: begin
                    if (r_state != ST_FAULT) begin
                        w_cmd_move  = 1'b1;
                        w_cmd_state = ST_HALTED;
                    end
                end
                CMD_RUN: begin
                    if ((r_state == ST_HALTED) || (r_state == ST_STEP)) begin
                        w_cmd_move  = 1'b1;
                        w_cmd_state = ST_RUN;
                    end
                end
                CMD_STEP: begin
                    if (r_state == ST_HALTED) begin
                        w_cmd_move  = 1'b1;
                        w_cmd_state = ST_STEP;
                    end
                end
                CMD_RESET_PC: begin
                    w_cmd_move  = 1'b1;
                    w_cmd_state = ST_PCRST;
                end
                default: begin
                    w_cmd_move  = 1'b0;
                    w_cmd_state = r_state;
                end
            endcase
        end

        w_next_state = r_state;
        w_set_first  = 1'b0;
        w_load_step  = 1'b0;
        w_bp_take    = 1'b0;
        if (r_state == ST_PCRST) begin
            w_next_state = ST_HALTED;
        end else if (w_fault_trap) begin
            w_next_state = ST_FAULT;
        end else if (w_cmd_move) begin
            w_next_state = w_cmd_state;
            w_set_first  = (w_cmd_state == ST_RUN);
            w_load_step  = (w_cmd_state == ST_STEP);
        end else if (w_bp_trap) begin
            w_next_state = ST_HALTED;
            w_bp_take    = 1'b1;
        end else if ((r_state == ST_STEP) && w_exec && (r_step_cnt == PC_W'(1))) begin
            w_next_state = ST_HALTED;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HALTED;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Breakpoint, step budget, resume marker, bp_hit pulse and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bp_addr   <= '0;
            r_bp_en     <= 1'b0;
            r_step_cnt  <= '0;
            r_first_cyc <= 1'b0;
            r_bp_hit    <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            if (w_cmd_acc && (cmd_op == CMD_SET_BP)) begin
                r_bp_addr <= cmd_arg;
                r_bp_en   <= 1'b1;
            end else if (w_cmd_acc && (cmd_op == CMD_CLR_BP)) begin
                r_bp_en   <= 1'b0;
            end

            if (w_load_step) begin
                r_step_cnt <= (cmd_arg == '0) ? PC_W'(1) : cmd_arg;
            end else if ((r_state == ST_STEP) && w_exec) begin
                r_step_cnt <= r_step_cnt - PC_W'(1);
            end

            // The marker survives exactly one RUN cycle so the instruction at the breakpoint can retire on resume
            if (w_set_first) begin
                r_first_cyc <= 1'b1;
            end else if (r_state == ST_RUN) begin
                r_first_cyc <= 1'b0;
            end

            r_bp_hit <= w_bp_take;

            if (r_state == ST_PCRST) begin
                r_instr_cnt <= '0;
            end else if (w_exec) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_we         = dec_pc_we         & w_exec;
    assign reg_write_en  = dec_reg_write_en  & w_exec;
    assign flag_write_en = dec_flag_write_en & w_exec;
    assign dmem_write_en = dec_dmem_write_en & w_exec;
    assign imem_we       = dec_imem_we       & w_exec;
    assign pc_rst        = (r_state == ST_PCRST);
    assign halted        = (r_state == ST_HALTED);
    assign fault         = (r_state == ST_FAULT);
    assign bp_hit        = r_bp_hit;
    assign instr_cnt     = r_instr_cnt;

endmodule
